// File: rtl/line_frame_serializer_if.sv
// Line-in / byte-out signal bundle for line_frame_serializer.
// master = serializer side, slave = print decoder + FIFO side.
interface line_frame_serializer_if #(
  parameter int HEAD_WIDTH = 384
);
  logic                  line_valid;
  logic [HEAD_WIDTH-1:0] line_data;
  logic                  fifo_full;
  logic                  fifo_write_enable;
  logic [7:0]            fifo_write_data;

  modport master (
    input  line_valid,
    input  line_data,
    input  fifo_full,
    output fifo_write_enable,
    output fifo_write_data
  );

  modport slave (
    output line_valid,
    output line_data,
    output fifo_full,
    input  fifo_write_enable,
    input  fifo_write_data
  );
endinterface

// File: rtl/line_frame_serializer.sv
// Frames each print line as "LINE:" SEQ payload [CRC] ":" into the UART TX FIFO, one byte per clock, stalling on fifo_full.
// One pending line is buffered while busy; further lines are dropped and counted. CRC byte enabled by LINE_FRAME_CRC_EN.
module line_frame_serializer #(
  parameter int HEAD_WIDTH     = 384,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  line_frame_serializer_if.master   bus,
  output logic                      busy,
  output logic [7:0]                seq,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int P     = HEAD_WIDTH / 8;
  localparam int IDX_W = ($clog2(P) > 3) ? $clog2(P) : 3;
  localparam logic [IDX_W-1:0] LAST_HDR = IDX_W'(4);
  localparam logic [IDX_W-1:0] LAST_PAY = IDX_W'(P - 1);

`ifdef LINE_FRAME_CRC_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_SEQ, S_PAYLOAD, S_CRC, S_TRAILER
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_SEQ, S_PAYLOAD, S_TRAILER
  } state_t;
`endif

  state_t                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [HEAD_WIDTH-1:0]     work_q;
  logic [HEAD_WIDTH-1:0]     pend_q;
  logic                      pend_vld_q;
  logic [7:0]                seq_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;

  logic       wr;
  logic       trailer_wr;
  logic [7:0] cur_byte;

`ifdef LINE_FRAME_CRC_EN
  logic [7:0] crc_q;
  logic [7:0] crc_d;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  // SEQ restarts the running CRC; each payload byte folds in as it is written.
  always_comb begin
    crc_d = crc_q;
    if (state_q == S_SEQ) begin
      crc_d = crc8_byte(8'h00, seq_q);
    end else if (state_q == S_PAYLOAD) begin
      crc_d = crc8_byte(crc_q, work_q[7:0]);
    end
  end
`endif

  assign wr         = (state_q != S_IDLE) && !bus.fifo_full;
  assign trailer_wr = wr && (state_q == S_TRAILER);

  always_comb begin
    cur_byte = 8'h00;
    case (state_q)
      S_HEADER: begin
        case (idx_q[2:0])
          3'd0:    cur_byte = 8'h4C;
          3'd1:    cur_byte = 8'h49;
          3'd2:    cur_byte = 8'h4E;
          3'd3:    cur_byte = 8'h45;
          default: cur_byte = 8'h3A;
        endcase
      end
      S_SEQ:     cur_byte = seq_q;
      // The working register shifts down one byte per payload write.
      S_PAYLOAD: cur_byte = work_q[7:0];
`ifdef LINE_FRAME_CRC_EN
      S_CRC:     cur_byte = crc_q;
`endif
      S_TRAILER: cur_byte = 8'h3A;
      default:   cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      work_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      seq_q      <= 8'h00;
      drop_q     <= '0;
`ifdef LINE_FRAME_CRC_EN
      crc_q      <= 8'h00;
`endif
    end else begin
      if (wr) begin
        case (state_q)
          S_HEADER: begin
            if (idx_q == LAST_HDR) begin
              state_q <= S_SEQ;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
          S_SEQ: begin
            state_q <= S_PAYLOAD;
            idx_q   <= '0;
`ifdef LINE_FRAME_CRC_EN
            crc_q   <= crc_d;
`endif
          end
          S_PAYLOAD: begin
            work_q <= work_q >> 8;
`ifdef LINE_FRAME_CRC_EN
            crc_q  <= crc_d;
`endif
            if (idx_q == LAST_PAY) begin
`ifdef LINE_FRAME_CRC_EN
              state_q <= S_CRC;
`else
              state_q <= S_TRAILER;
`endif
              idx_q <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
`ifdef LINE_FRAME_CRC_EN
          S_CRC: begin
            state_q <= S_TRAILER;
            idx_q   <= '0;
          end
`endif
          S_TRAILER: begin
            seq_q <= seq_q + 8'd1;
            idx_q <= '0;
            // Chain straight into the next frame when a line is waiting or arriving now.
            if (pend_vld_q) begin
              work_q     <= pend_q;
              pend_vld_q <= 1'b0;
              state_q    <= S_HEADER;
            end else if (bus.line_valid) begin
              work_q  <= bus.line_data;
              state_q <= S_HEADER;
            end else begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end

      if (bus.line_valid) begin
        if (state_q == S_IDLE) begin
          work_q  <= bus.line_data;
          state_q <= S_HEADER;
          idx_q   <= '0;
        end else if (!pend_vld_q) begin
          if (!trailer_wr) begin
            pend_q     <= bus.line_data;
            pend_vld_q <= 1'b1;
          end
        end else if (trailer_wr) begin
          pend_q     <= bus.line_data;
          pend_vld_q <= 1'b1;
        end else if (drop_q != '1) begin
          drop_q <= drop_q + DROP_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign bus.fifo_write_enable = wr;
  assign bus.fifo_write_data   = cur_byte;
  assign busy                  = (state_q != S_IDLE) || pend_vld_q;
  assign seq                   = seq_q;
  assign drop_count            = drop_q;

endmodule

// File: tb/tb_line_frame_serializer.sv
// Directed bench for line_frame_serializer: vector table of single frames plus stall, chaining, wrap, drop and reset sequences.
module tb_line_frame_serializer;
  localparam int HW = 384;
  localparam int P  = HW / 8;
`ifdef LINE_FRAME_CRC_EN
  localparam int FLEN = P + 8;
`else
  localparam int FLEN = P + 7;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [7:0] seq;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  line_frame_serializer_if #(.HEAD_WIDTH(HW)) bus ();

  line_frame_serializer #(.HEAD_WIDTH(HW), .DROP_CNT_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .seq        (seq),
    .drop_count (drop_count)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [7:0] wq[$];
  int         wc[$];
  logic [7:0] ef[0:127];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.fifo_write_enable === 1'b1) begin
      wq.push_back(bus.fifo_write_data);
      wc.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] qget(input int i);
    if (i < wq.size()) return wq[i];
    return 8'hxx;
  endfunction

  function automatic logic [7:0] crc_bits(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
    return r;
  endfunction

  task automatic model_frame(input logic [HW-1:0] line, input logic [7:0] s, input int base);
    logic [7:0] c;
    logic [7:0] b;
    ef[base+0] = 8'h4C; ef[base+1] = 8'h49; ef[base+2] = 8'h4E;
    ef[base+3] = 8'h45; ef[base+4] = 8'h3A; ef[base+5] = s;
    c = crc_bits(8'h00, s);
    for (int k = 0; k < P; k++) begin
      b = line[8*k +: 8];
      ef[base+6+k] = b;
      c = crc_bits(c, b);
    end
`ifdef LINE_FRAME_CRC_EN
    ef[base+6+P] = c;
`endif
    ef[base+FLEN-1] = 8'h3A;
  endtask

  task automatic cmp_model(input string nm, input int n);
    int bad;
    bad = -1;
    for (int i = 0; i < n; i++) begin
      if (bad < 0 && qget(i) !== ef[i]) bad = i;
    end
    tests++;
    if (bad >= 0 || wq.size() != n) begin
      fails++;
      if (bad < 0) bad = n;
      $display("FAIL %s: byte %0d got %0h expected %0h (frame bytes %0d, expected %0d)",
               nm, bad, qget(bad), (bad < n) ? ef[bad] : 8'h00, wq.size(), n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [HW-1:0] l);
    bus.line_data  = l;
    bus.line_valid = 1'b1;
    step();
    bus.line_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic wait_writes(input string nm, input int cnt, input int budget);
    int n;
    n = 0;
    while (wq.size() < cnt && n < budget) begin
      step();
      n++;
    end
    if (wq.size() < cnt) chk({nm, "_reach"}, wq.size(), cnt);
  endtask

  task automatic clear_q();
    wq.delete();
    wc.delete();
  endtask

  typedef struct {
    logic [HW-1:0] line;
    int            pos_a;
    logic [7:0]    exp_a;
    int            pos_b;
    logic [7:0]    exp_b;
  } vec_t;

  vec_t       vt[4];
  logic [7:0] exp_seq;
  logic [7:0] exp_drop;
  logic [HW-1:0] l;
  int vc;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0].line = '0; vt[0].line[7:0] = 8'h01; vt[0].line[383:376] = 8'hAA;
    vt[0].pos_a = 6;  vt[0].exp_a = 8'h01; vt[0].pos_b = 53; vt[0].exp_b = 8'hAA;
    vt[1].line = '0;
    vt[1].pos_a = 6;  vt[1].exp_a = 8'h00; vt[1].pos_b = FLEN - 1; vt[1].exp_b = 8'h3A;
    vt[2].line = '1;
    vt[2].pos_a = 30; vt[2].exp_a = 8'hFF; vt[2].pos_b = 0;  vt[2].exp_b = 8'h4C;
    for (int k = 0; k < P; k++) vt[3].line[8*k +: 8] = 8'(k);
    vt[3].pos_a = 16; vt[3].exp_a = 8'h0A; vt[3].pos_b = 53; vt[3].exp_b = 8'h2F;

    reset = 1'b0;
    bus.line_valid = 1'b0;
    bus.line_data  = '0;
    bus.fifo_full  = 1'b0;
    step(); step(); step();
    chk("rst_we", bus.fifo_write_enable, 0);
    chk("rst_data", bus.fifo_write_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_seq", seq, 8'h00);
    chk("rst_drop", drop_count, 8'h00);
    reset = 1'b1;
    step();
    exp_seq  = 8'h00;
    exp_drop = 8'h00;

    for (int v = 0; v < 4; v++) begin
      clear_q();
      vc = cyc;
      pulse(vt[v].line);
      wait_idle("vec", 200);
      chk("vec_len", wq.size(), FLEN);
      chk("vec_first_cycle", (wc.size() > 0) ? wc[0] : -1, vc + 1);
      chk("vec_contig", (wc.size() > 0) ? (wc[wc.size()-1] - wc[0]) : -1, FLEN - 1);
      chk("vec_probe_a", qget(vt[v].pos_a), vt[v].exp_a);
      chk("vec_probe_b", qget(vt[v].pos_b), vt[v].exp_b);
      chk("vec_seq_byte", qget(5), exp_seq);
      model_frame(vt[v].line, exp_seq, 0);
      cmp_model("vec_frame", FLEN);
      exp_seq = exp_seq + 8'd1;
      chk("vec_seq_out", seq, exp_seq);
    end

    // Stall on payload byte 20.
    l = '0; l[7:0] = 8'h11; l[167:160] = 8'h5C;
    clear_q();
    pulse(l);
    wait_writes("stall", 26, 100);
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0 || i == 9) begin
        chk("stall_we", bus.fifo_write_enable, 0);
        chk("stall_data", bus.fifo_write_data, 8'h5C);
      end
    end
    chk("stall_no_writes", wq.size(), 26);
    bus.fifo_full = 1'b0;
    wait_idle("stall", 200);
    chk("stall_len", wq.size(), FLEN);
    chk("stall_byte20", qget(26), 8'h5C);
    model_frame(l, exp_seq, 0);
    cmp_model("stall_frame", FLEN);
    exp_seq = exp_seq + 8'd1;

    // Three lines two cycles apart: two back-to-back frames, third dropped.
    clear_q();
    l = '0; l[15:8] = 8'h33;
    pulse(l);
    step();
    pulse(~l);
    step();
    pulse('0);
    wait_idle("b2b", 400);
    chk("b2b_len", wq.size(), 2 * FLEN);
    chk("b2b_contig", (wc.size() > 0) ? (wc[wc.size()-1] - wc[0]) : -1, 2 * FLEN - 1);
    model_frame(l, exp_seq, 0);
    model_frame(~l, exp_seq + 8'd1, FLEN);
    cmp_model("b2b_frames", 2 * FLEN);
    exp_drop = 8'd1;
    chk("b2b_drop", drop_count, exp_drop);
    exp_seq = exp_seq + 8'd2;
    chk("b2b_seq", seq, exp_seq);

    // Line arriving in the trailer cycle with pending empty.
    clear_q();
    l = '0; l[31:24] = 8'h77;
    pulse(l);
    wait_writes("trl", FLEN - 1, 100);
    chk("trl_we", bus.fifo_write_enable, 1);
    pulse(~l);
    wait_idle("trl", 400);
    model_frame(l, exp_seq, 0);
    model_frame(~l, exp_seq + 8'd1, FLEN);
    cmp_model("trl_frames", 2 * FLEN);
    chk("trl_drop", drop_count, exp_drop);
    exp_seq = exp_seq + 8'd2;
    chk("trl_seq", seq, exp_seq);

    // Run frames until the sequence number wraps.
    while (exp_seq != 8'h00) begin
      clear_q();
      pulse('0);
      wait_writes("wrap", FLEN, 200);
      step();
      exp_seq = exp_seq + 8'd1;
    end
    chk("wrap_seq_out", seq, 8'h00);
    clear_q();
    pulse('0);
    wait_idle("wrap", 200);
    chk("wrap_seq_byte", qget(5), 8'h00);

    // Continuous line_valid forces hundreds of drops.
    clear_q();
    bus.line_data  = '0;
    bus.line_valid = 1'b1;
    for (int i = 0; i < 320; i++) step();
    bus.line_valid = 1'b0;
    wait_idle("sat", 500);
    chk("sat_drop", drop_count, 8'hFF);
    chk("sat_whole_frames", wq.size() % FLEN, 0);

    // Reset in the middle of the payload.
    clear_q();
    pulse('1);
    wait_writes("rstmid", 30, 100);
    reset = 1'b0;
    #1;
    chk("rstmid_we", bus.fifo_write_enable, 0);
    step(); step(); step();
    chk("rstmid_no_writes", wq.size(), 30);
    chk("rstmid_seq", seq, 8'h00);
    chk("rstmid_drop", drop_count, 8'h00);
    chk("rstmid_busy", busy, 0);
    reset = 1'b1;
    step();

    // Seq 0, all-zero payload after reset.
    clear_q();
    pulse('0);
    wait_idle("zero", 200);
    chk("zero_len", wq.size(), FLEN);
    chk("zero_seq_byte", qget(5), 8'h00);
`ifdef LINE_FRAME_CRC_EN
    chk("zero_crc", qget(6 + P), 8'h00);
`endif

    // Seq 0, payload byte 0 = 0x01.
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    clear_q();
    l = '0; l[7:0] = 8'h01;
    pulse(l);
    wait_idle("one", 200);
    model_frame(l, 8'h00, 0);
`ifdef LINE_FRAME_CRC_EN
    chk("one_crc", qget(6 + P), ef[6 + P]);
`endif
    cmp_model("one_frame", FLEN);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
